// File: rtl/pwr_cntr_reader_if.sv
// Event / readout bundle for the power-class counter bank.
// Latency: pure wiring, no storage.
// Backpressure: rd_ready from the consumer stalls the readout stream; events are never stalled.
//
// Ports:
//   evt_valid/evt_idx/evt_weight - weighted 0->1 transition from the netlist
//   start                         - request a full readout scan
//   rd_valid/rd_ready/rd_idx/rd_data - readout stream, one entry per class
//   busy/done/total/sat           - scan status, grand total, sticky saturation flag
// Modports: master = producer/consumer side (bench), slave = counter bank.
interface pwr_cntr_reader_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16,
    parameter int WGT_W = 4
);
    logic                   evt_valid;
    logic [IDX_W-1:0]       evt_idx;
    logic [WGT_W-1:0]       evt_weight;
    logic                   start;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [IDX_W-1:0]       rd_idx;
    logic [CNT_W-1:0]       rd_data;
    logic                   busy;
    logic                   done;
    logic [CNT_W+IDX_W-1:0] total;
    logic                   sat;

    modport master (
        output evt_valid, evt_idx, evt_weight, start, rd_ready,
        input  rd_valid, rd_idx, rd_data, busy, done, total, sat
    );

    modport slave (
        input  evt_valid, evt_idx, evt_weight, start, rd_ready,
        output rd_valid, rd_idx, rd_data, busy, done, total, sat
    );
endinterface

// File: rtl/pwr_cntr_reader.sv
// Per-power-class weighted counter bank with a streamed readout scan and grand total.
// Latency: events land one edge after evt_valid; first entry valid the cycle after start.
// Backpressure: rd_ready low holds the registered rd_idx/rd_data snapshot; events keep counting.
//
// Ports: clk, reset_L (async active-low), bus (pwr_cntr_reader_if.slave).
// Optional build macro: PWR_CLR_ON_READ_EN - each accepted entry clears its counter.
// Counters saturate at all-ones; a clamp sets the sticky sat flag until reset.
module pwr_cntr_reader #(
    parameter int N_CNTR = 8,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16,
    parameter int WGT_W  = 4
) (
    input  logic                clk,
    input  logic                reset_L,
    pwr_cntr_reader_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNTR - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cntr     [N_CNTR];
    logic [CNT_W-1:0]  cntr_nxt [N_CNTR];
    logic [N_CNTR-1:0] clamp;
    logic [CNT_W:0]    sum;
    logic [WGT_W-1:0]  evt_w;
    logic [IDX_W-1:0]  nxt_idx;
    logic              hshk;

    assign evt_w   = bus.evt_weight;
    assign hshk    = bus.rd_valid & bus.rd_ready;
    assign nxt_idx = bus.rd_idx + IDX_W'(1);

    // Next value per class. An out-of-range evt_idx matches no class and is dropped.
    // With clear-on-read, the clear is applied first so a same-edge event survives.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CNTR; i++) begin
            cntr_nxt[i] = cntr[i];
            clamp[i]    = 1'b0;
`ifdef PWR_CLR_ON_READ_EN
            if (hshk && bus.rd_idx == IDX_W'(i)) begin
                cntr_nxt[i] = '0;
            end
`endif
            if (bus.evt_valid && bus.evt_idx == IDX_W'(i)) begin
                sum = {1'b0, cntr_nxt[i]} + (CNT_W+1)'(evt_w);
                if (sum[CNT_W]) begin
                    cntr_nxt[i] = CNT_MAX;
                    clamp[i]    = 1'b1;
                end else begin
                    cntr_nxt[i] = sum[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < N_CNTR; i++) begin
                cntr[i] <= '0;
            end
            bus.sat <= 1'b0;
        end else begin
            for (int i = 0; i < N_CNTR; i++) begin
                cntr[i] <= cntr_nxt[i];
            end
            if (|clamp) begin
                bus.sat <= 1'b1;
            end
        end
    end

    // Scan FSM. rd_data is always a snapshot of the pre-edge counter value,
    // so it never tracks events that arrive while the entry is stalled.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            bus.rd_valid <= 1'b0;
            bus.rd_idx   <= '0;
            bus.rd_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.total    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state        <= SEND;
                        bus.busy     <= 1'b1;
                        bus.rd_valid <= 1'b1;
                        bus.rd_idx   <= '0;
                        bus.rd_data  <= cntr[0];
                        bus.total    <= '0;
                    end
                end
                SEND: begin
                    if (hshk) begin
                        bus.total <= bus.total + (CNT_W+IDX_W)'(bus.rd_data);
                        if (bus.rd_idx == LAST_IDX) begin
                            bus.rd_valid <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.rd_idx  <= nxt_idx;
                            bus.rd_data <= cntr[nxt_idx];
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/pwr_cntr_reader.md
Name: pwr_cntr_reader

Overview:
- Readout end of the gate power-accounting path. Gate cells report weighted 0->1 output transitions; this block is the counter bank that receives them.
- Accumulates one weighted counter per power class (PwrC index).
- On request, streams every counter out over a valid/ready interface and then reports the grand total.
- Sits between the gate-level netlist under analysis and the bench/report logic.

Parameters:
N_CNTR, 8, number of power-class counters (indices 0..N_CNTR-1)
IDX_W, 3, width of class index; must satisfy 2^IDX_W >= N_CNTR
CNT_W, 16, width of each class counter
WGT_W, 4, width of per-event power weight

Ports:
clk  in  1  single clock, rising edge
reset_L  in  1  asynchronous active-low reset
evt_valid  in  1  one weighted transition event this cycle
evt_idx  in  IDX_W  power class of the event
evt_weight  in  WGT_W  weight to add
start  in  1  request a full readout scan
rd_valid  out  1  rd_idx/rd_data valid
rd_ready  in  1  consumer accepts current entry
rd_idx  out  IDX_W  class index being output
rd_data  out  CNT_W  counter value for rd_idx
busy  out  1  scan in progress (state != IDLE)
done  out  1  one-cycle pulse, scan complete
total  out  CNT_W+IDX_W  sum of all entries sent in last scan
sat  out  1  sticky: some counter saturated

Behaviour:
- Reset (reset_L=0, async): all counters 0, state IDLE, rd_valid=0, rd_idx=0, rd_data=0, busy=0, done=0, total=0, sat=0.
- Increment: at each edge with evt_valid=1 and evt_idx<N_CNTR: cntr[evt_idx] <= min(cntr+evt_weight, 2^CNT_W-1).
  - Clamping sets sat=1. sat clears only on reset.
  - evt_idx>=N_CNTR: event dropped, no state change.
  - evt_weight=0: counter unchanged.
- Increments are accepted in every state, including during a scan.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 at an edge: state->SEND, rd_idx<=0, rd_data<=cntr[0] (pre-edge value), total<=0, rd_valid<=1.
  - rd_valid is therefore high the cycle after start is sampled.
- SEND:
  - rd_idx/rd_data are a registered snapshot, held stable while rd_valid=1 and rd_ready=0, even if that counter increments meanwhile.
  - Handshake = rd_valid&rd_ready at an edge: total <= total + rd_data (zero-extended).
  - On handshake with rd_idx<N_CNTR-1: rd_idx+1, snapshot of cntr[rd_idx+1] (pre-edge value), rd_valid stays 1. Back-to-back, one entry per cycle at full throughput.
  - On handshake with rd_idx=N_CNTR-1: rd_valid<=0, state->DONE.
- DONE: done=1 for exactly one cycle, then state->IDLE.
  - total holds its value until the next start.
- start is ignored in SEND and DONE.
- The total width never overflows, since N_CNTR*(2^CNT_W-1) fits in CNT_W+IDX_W bits.
- Reset mid-scan: immediate return to reset values; the partial scan is discarded.

Optional Feature:
- Macro: PWR_CLR_ON_READ_EN.
- Defined: on each handshake, cntr[rd_idx] is cleared to 0.
  - If an event targets the same index at the same edge, the counter becomes min(evt_weight, max). The event is not lost and is not counted in the sent value.
- Undefined: reading is non-destructive; counters change only through events and reset.

Test Plan:
- Reset, then start with rd_ready=1 -> 8 entries with rd_data=0, idx 0..7 in consecutive cycles; done pulse; total=0; sat=0.
- Events idx2 w5, idx2 w3, idx7 w15, then scan -> rd_data[2]=8, rd_data[7]=15, others 0; total=23.
- 4370 events idx0 w15 (65550 > 65535) -> cntr[0]=65535, sat=1. Later events keep 65535 and sat stays 1.
- Scan with rd_ready low 3 cycles at idx3 while idx3 events w4 arrive -> rd_data for idx3 stays at the snapshot value. Next scan shows snapshot+4 per event without the macro; with the macro, shows only the events arriving on or after the idx3 handshake.
- evt_idx=7 with N_CNTR=6, or start during SEND -> no counter change, no restart; scan finishes normally.
- Assert reset_L mid-scan at idx4 -> rd_valid, busy, and total are 0 at once; a subsequent start yields all-zero entries.
